// File: rtl/mult_pkg.sv
// mult_pkg: shared state, width and control types for the shift-add multiplier scheduler
package mult_pkg;
  localparam int N_BITS = 8;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TEST, S_ADD, S_SUB, S_SHIFT, S_DONE} state_t;
  typedef struct packed {
    logic clr_ld;
    logic add;
    logic sub;
    logic shift;
  } ctrl_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way arbiter; round-robin pointer when MULT_SCHED_RR_EN is defined,
// otherwise fixed priority to requester 0
module rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  output logic [1:0] o_gnt
);
`ifdef MULT_SCHED_RR_EN
  logic r_ptr;
  always_ff @(posedge i_clk)
    if (i_rst) r_ptr <= 1'b0;
    else if (i_upd && |o_gnt) r_ptr <= o_gnt[0];
  always_comb o_gnt = (i_req == 2'b11) ? (r_ptr ? 2'b10 : 2'b01) : i_req;
`else
  logic w_unused;
  assign w_unused = i_clk ^ i_rst ^ i_upd;
  assign o_gnt = i_req[0] ? 2'b01 : {i_req[1], 1'b0};
`endif
endmodule

// File: rtl/mult_sched.sv
// mult_sched: arbitrated, counter-driven sequencer for the shared shift-add signed multiplier.
// Define MULT_SCHED_RR_EN for round-robin arbitration (fixed priority otherwise).
module mult_sched
  import mult_pkg::*;
#(
  parameter int N = N_BITS
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_m,
  output logic [1:0] o_gnt,
  output logic       o_sel,
  output logic       o_clr_ld,
  output logic       o_add,
  output logic       o_sub,
  output logic       o_shift,
  output logic [1:0] o_done,
  output logic       o_busy
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [1:0] r_gnt, w_arb;
  logic r_sel, w_last, w_live, w_start;
  ctrl_t w_ctrl;
  assign w_last = r_cnt == CW'(N - 1);
  assign w_live = r_state inside {S_LOAD, S_TEST, S_ADD, S_SUB, S_SHIFT};
  assign w_start = r_state == S_IDLE && |i_req;
  rr_arbiter2 u_arb (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_req(i_req),
    .i_upd(w_start),
    .o_gnt(w_arb)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = |i_req ? S_LOAD : S_IDLE;
      S_LOAD:  w_next = S_TEST;
      S_TEST:  w_next = i_m ? (w_last ? S_SUB : S_ADD) : S_SHIFT;
      S_ADD:   w_next = S_SHIFT;
      S_SUB:   w_next = S_SHIFT;
      S_SHIFT: w_next = w_last ? S_DONE : S_TEST;
      default: w_next = S_IDLE;
    endcase
    // losing the granted request mid-job abandons it without a done pulse
    if (w_live && !(|(i_req & r_gnt))) w_next = S_IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_gnt   <= 2'b00;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) r_cnt <= '0;
      if (r_state == S_SHIFT) r_cnt <= r_cnt + CW'(1);
      if (w_start) begin
        r_gnt <= w_arb;
        r_sel <= w_arb[1];
      end
      if (w_next == S_IDLE) r_gnt <= 2'b00;
    end
  end
  assign w_ctrl = '{clr_ld: r_state == S_LOAD, add: r_state == S_ADD,
                    sub: r_state == S_SUB, shift: r_state == S_SHIFT};
  assign o_clr_ld = w_ctrl.clr_ld;
  assign o_add    = w_ctrl.add;
  assign o_sub    = w_ctrl.sub;
  assign o_shift  = w_ctrl.shift;
  assign o_gnt    = r_gnt;
  assign o_sel    = r_sel;
  assign o_done   = (r_state == S_DONE) ? (r_sel ? 2'b10 : 2'b01) : 2'b00;
  assign o_busy   = r_state != S_IDLE;
endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: drives mult_sched with a behavioural datapath and checks it each cycle
// against a job-level model of the control sequence and signed product.
module tb_mult_sched;
  localparam int NB = 8;
`ifdef MULT_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct packed {
    logic [1:0]  gnt;
    logic [3:0]  ctl;
    logic [1:0]  done;
    logic        busy;
    logic        live;
    logic [15:0] prod;
  } ev_t;

  logic clk = 0, rst = 1, m;
  logic [1:0] req = 0, gnt, done;
  logic sel, clr_ld, add, sub, shift, busy;
  logic dx;
  logic [7:0] da, db, ds;
  logic [7:0] b_op[2], s_op[2];
  ev_t exp_q[$];
  logic mptr;
  bit started = 0;
  int n_chk = 0, n_fail = 0;

  mult_sched dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_m(m),
    .o_gnt(gnt), .o_sel(sel), .o_clr_ld(clr_ld), .o_add(add), .o_sub(sub),
    .o_shift(shift), .o_done(done), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // shared datapath: X:A:B shift chain with adder/subtractor on A
  assign m = db[0];
  always @(posedge clk) begin
    if (clr_ld) begin
      dx <= 1'b0; da <= 8'h00; db <= b_op[sel]; ds <= s_op[sel];
    end else if (add) begin
      {dx, da} <= {da[7], da} + {ds[7], ds};
    end else if (sub) begin
      {dx, da} <= {da[7], da} - {ds[7], ds};
    end else if (shift) begin
      da <= {dx, da[7:1]}; db <= {da[0], db[7:1]};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // job model: one entry per cycle of a job, derived from the multiplier bits
  task automatic push_job(input int w);
    logic [1:0] g;
    int pp;
    g = (w == 1) ? 2'b10 : 2'b01;
    pp = $signed(s_op[w]) * $signed(b_op[w]);
    exp_q.push_back('{g, 4'b1000, 2'b00, 1'b1, 1'b1, 16'(pp)});
    for (int i = 0; i < NB; i++) begin
      exp_q.push_back('{g, 4'b0000, 2'b00, 1'b1, 1'b1, 16'(pp)});
      if (b_op[w][i]) exp_q.push_back('{g, (i == NB - 1) ? 4'b0010 : 4'b0100, 2'b00, 1'b1, 1'b1, 16'(pp)});
      exp_q.push_back('{g, 4'b0001, 2'b00, 1'b1, 1'b1, 16'(pp)});
    end
    exp_q.push_back('{g, 4'b0000, g, 1'b1, 1'b0, 16'(pp)});
  endtask

  always @(posedge clk) begin
    int w;
    if (rst) begin
      exp_q.delete();
      mptr = 1'b0;
    end else if (exp_q.size() != 0) begin
      if (exp_q[0].live && (req & exp_q[0].gnt) == 2'b00) exp_q.delete();
      else exp_q.delete(0);
    end else if (req != 2'b00) begin
      w = (req == 2'b11) ? (RR ? int'(mptr) : 0) : int'(req[1]);
      push_job(w);
      mptr = (w == 0);
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (started) begin
      e = (exp_q.size() != 0) ? exp_q[0] : '0;
      chk("outputs", {gnt, clr_ld, add, sub, shift, done, busy},
          {e.gnt, e.ctl, e.done, e.busy});
      if (e.gnt != 2'b00) chk("sel", sel, e.gnt[1]);
      if (e.done != 2'b00 && done != 2'b00) chk("product", {da, db}, e.prod);
    end
  end

  task automatic wait_done(output int k, output logic [1:0] d, output int nclr, output int nadd,
                           output int nsub, output int nsh);
    k = 0; d = 0; nclr = 0; nadd = 0; nsub = 0; nsh = 0;
    while (k < 40 && d == 2'b00) begin
      @(negedge clk);
      k++;
      nclr += clr_ld; nadd += add; nsub += sub; nsh += shift;
      d = done;
    end
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, nc, na, ns, nh;
    logic [1:0] d, d1, d2, d3;
    b_op[0] = 8'h00; s_op[0] = 8'h11; b_op[1] = 8'hFF; s_op[1] = 8'hF3;
    do_reset();
    started = 1;
    chk("reset_outputs", {gnt, clr_ld, add, sub, shift, done, busy}, 0);
    // B=0x00 on requester 0
    req = 2'b01;
    wait_done(k, d, nc, na, ns, nh);
    chk("b00_done_cycle", k, 18); chk("b00_done", d, 2'b01);
    chk("b00_clr", nc, 1); chk("b00_shift", nh, 8); chk("b00_addsub", na + ns, 0);
    req = 2'b00;
    @(negedge clk);
    chk("b00_gnt_idle", gnt, 2'b00); chk("b00_busy_idle", busy, 0);
    // B=0x81, S=5 -> -635
    b_op[0] = 8'h81; s_op[0] = 8'h05;
    req = 2'b01;
    wait_done(k, d, nc, na, ns, nh);
    chk("b81_done_cycle", k, 20); chk("b81_add", na, 1); chk("b81_sub", ns, 1);
    chk("b81_shift", nh, 8); chk("b81_product", {da, db}, 16'hFD85);
    req = 2'b00;
    @(negedge clk);
    // B=0xFF on requester 1, S=-13 -> 13
    req = 2'b10;
    wait_done(k, d, nc, na, ns, nh);
    chk("bff_done_cycle", k, 26); chk("bff_done", d, 2'b10); chk("bff_add", na, 7);
    chk("bff_sub", ns, 1); chk("bff_shift", nh, 8); chk("bff_product", {da, db}, 16'h000D);
    req = 2'b00;
    @(negedge clk);
    // Req=11 held across three jobs
    b_op[0] = 8'h03; s_op[0] = 8'h7F; b_op[1] = 8'h10; s_op[1] = 8'h80;
    req = 2'b11;
    wait_done(k, d1, nc, na, ns, nh);
    @(negedge clk);
    wait_done(k, d2, nc, na, ns, nh);
    @(negedge clk);
    wait_done(k, d3, nc, na, ns, nh);
    req = 2'b00;
    chk("held_done1", d1, 2'b01);
    chk("held_done2", d2, RR ? 2'b10 : 2'b01);
    chk("held_done3", d3, 2'b01);
    @(negedge clk);
    // abort: Req[0] dropped at cycle 6
    do_reset();
    b_op[0] = 8'h00;
    req = 2'b11;
    repeat (6) @(negedge clk);
    req = 2'b10;
    @(negedge clk);
    chk("abort_gnt", gnt, 2'b00); chk("abort_busy", busy, 0); chk("abort_done", done, 2'b00);
    @(negedge clk);
    chk("abort_regrant", gnt, 2'b10); chk("abort_load", clr_ld, 1);
    wait_done(k, d, nc, na, ns, nh);
    chk("abort_job_done", d, 2'b10);
    req = 2'b00;
    @(negedge clk);
    // reset while in ADD
    b_op[0] = 8'h01;
    req = 2'b01;
    repeat (3) @(negedge clk);
    chk("rst_in_add", add, 1);
    rst = 1;
    @(negedge clk);
    chk("rst_outputs", {gnt, sel, clr_ld, add, sub, shift, done, busy}, 0);
    rst = 0;
    req = 2'b10;
    @(negedge clk);
    chk("rst_regrant", gnt, 2'b10);
    wait_done(k, d, nc, na, ns, nh);
    chk("rst_job_done", d, 2'b10);
    req = 2'b00;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_sched.md
# mult_sched

Controller and two-requester arbiter for the shared 8-bit shift-add signed multiplier datapath (registers X/A/B, adder/subtractor, shift chain). It grants the datapath to one requester at a time and steers the operand mux. It then sequences clear/load, add, subtract and shift cycles from the datapath's multiplier LSB, and signals completion with a one-cycle done pulse. It replaces the hard-wired per-bit state chain with a counter-driven state machine.

## Interface
- N_BITS, 8, multiplier width; number of shift iterations per job
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high reset
- Req  in  2  per-requester job request; held high until matching Done bit
- M  in  1  datapath B[0] (current multiplier LSB)
- Gnt  out  2  one-hot grant, registered, held for whole job
- Sel  out  1  operand-mux select = index of granted requester
- Clr_Ld  out  1  clear X/A, load B and S from selected requester
- Add  out  1  A <= A + S (with sign into X)
- Sub  out  1  A <= A - S (with sign into X)
- Shift  out  1  arithmetic right shift of X:A:B
- Done  out  2  one-cycle pulse to granted requester: product valid in A:B
- Busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, TEST, ADD, SUB, SHIFT, DONE. Outputs are a Moore decode of the registered state. At most one of Clr_Ld/Add/Sub/Shift is high in any cycle.
- IDLE: if any Req, arbitrate, register Gnt/Sel, clear bit counter, go to LOAD. Otherwise stay.
- LOAD: Clr_Ld=1, go to TEST.
- TEST: no control output. If M=1 and cnt<N_BITS-1, go to ADD. If M=1 and cnt==N_BITS-1, go to SUB (sign bit). Otherwise go to SHIFT.
- ADD / SUB: Add or Sub =1, go to SHIFT.
- SHIFT: Shift=1, cnt++. If cnt was N_BITS-1, go to DONE; else go to TEST.
- DONE: Done[Sel]=1, go to IDLE. Gnt drops on entry to IDLE.
- Counter: $clog2(N_BITS) bits, wraps only via reset/IDLE clear.
- Abort: granted Req bit low in any state LOAD..SHIFT. Next state is IDLE, no Done, Gnt=00. Datapath contents are undefined.
- Arbitration: round-robin pointer. Updated at grant to favor the non-granted requester. Simultaneous Req=11 goes to the pointer side. Requests arriving mid-job wait; no preemption.
- Reset (any state, including mid-job): next cycle IDLE. Gnt=00, Sel=0, Clr_Ld=Add=Sub=Shift=0, Done=00, Busy=0, cnt=0, pointer favors requester 0.

## Timing
- Req sampled in IDLE at cycle 0. LOAD is at cycle 1, with Gnt valid from cycle 1.
- Done at cycle 2·N_BITS + 2 + popcount(B operand). For N_BITS=8: 18 minimum, 26 maximum.
- M is sampled only in TEST. It must reflect B after the preceding LOAD/SHIFT edge. The datapath is assumed to update on the same Clk edge.
- Back-to-back: DONE → IDLE → LOAD. The minimum gap is one IDLE cycle between Done and the next Clr_Ld.
- Req dropping during DONE or IDLE has no effect on the completed job.

## Configuration
- MULT_SCHED_RR_EN defined: round-robin arbitration as above.
- Not defined: fixed priority, requester 0 always wins on Req=11. Pointer register is removed.

## Structure
- Shared package mult_pkg: state enum type, N_BITS default constant, control-output struct (clr_ld/add/sub/shift).
- One sub-module, rr_arbiter2: 2-way arbiter with pointer. Its inputs are Req and an update strobe; its output is a one-hot grant. Pointer logic is under MULT_SCHED_RR_EN.

## Test plan
- Reset, then Req=01 with B=0x00. Expect: Gnt=01 and Clr_Ld high at cycle 1 only; 8 Shift pulses; no Add/Sub; Done=01 at cycle 18; Gnt=00 at cycle 19.
- Req=01 with B=0x81. Expect: one Add before the first Shift; one Sub before the 8th Shift; Done at cycle 20. With S=0x05 the datapath product is 0xFD85 (5×−127=−635).
- Req=11 held continuously from reset. With the macro, grants go 01,10,01. Without it, grants go 01,01,01. Each grant has exactly one Done to the matching bit.
- Req=11, then Req[0] dropped at cycle 6. Expect: IDLE at cycle 7, Gnt=00, no Done[0]; Gnt=10 at cycle 8.
- Reset asserted while in ADD. Expect: next cycle all outputs 0, Busy=0; a fresh Req=10 gets Gnt=10 one cycle after sampling.
- B=0xFF. Expect: 7 Add, 1 Sub, 8 Shift, in strictly alternating TEST/op order; Done at cycle 26.
